// File: rtl/issue_scheduler.sv
// Round-robin issue scheduler: picks one valid, hazard-free pool slot per cycle into a
// registered valid/ready output stage, tracking in-flight destinations in a busy scoreboard.
module issue_scheduler #(
   parameter int COP_NUMS = 32'd1,
   parameter int PNUMS    = COP_NUMS + 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                FLUSH,
   input  logic [32*PNUMS-1:0] POOL_PC,
   input  logic [17*PNUMS-1:0] POOL_OPCODE,
   input  logic [5*PNUMS-1:0]  POOL_RD,
   input  logic [5*PNUMS-1:0]  POOL_RS1,
   input  logic [5*PNUMS-1:0]  POOL_RS2,
   input  logic [32*PNUMS-1:0] POOL_RINST,
   output logic [PNUMS-1:0]    POOL_ACCEPT,
   output logic                ISSUE_VALID,
   input  logic                ISSUE_READY,
   output logic [PNUMS-1:0]    ISSUE_SLOT,
   output logic [31:0]         ISSUE_PC,
   output logic [16:0]         ISSUE_OPCODE,
   output logic [4:0]          ISSUE_RD,
   output logic [4:0]          ISSUE_RS1,
   output logic [4:0]          ISSUE_RS2,
   output logic [31:0]         ISSUE_RINST,
   input  logic                WB_VALID,
   input  logic [4:0]          WB_RD,
   output logic [31:0]         BUSY_REGS
);

   localparam int PW = (PNUMS > 1) ? $clog2(PNUMS) : 1;

   // Handshake: the output stage transfers on a cycle where ISSUE_VALID && ISSUE_READY;
   // while ISSUE_VALID is high and ISSUE_READY is low every ISSUE_* output holds stable.
   logic             valid_q, valid_d;
   logic [PNUMS-1:0] slot_q, slot_d;
   logic [31:0]      pc_q, pc_d;
   logic [16:0]      opcode_q, opcode_d;
   logic [4:0]       rd_q, rd_d;
   logic [4:0]       rs1_q, rs1_d;
   logic [4:0]       rs2_q, rs2_d;
   logic [31:0]      rinst_q, rinst_d;
   logic [31:0]      busy_q, busy_d;
   logic [PW-1:0]    ptr_q, ptr_d;

   logic [PNUMS-1:0] slot_elig;
   logic [PNUMS-1:0] grant_oh;
   logic             found;
   logic             grant;
   logic [PW-1:0]    grant_idx;
   logic [31:0]      sel_pc;
   logic [16:0]      sel_opcode;
   logic [4:0]       sel_rd;
   logic [4:0]       sel_rs1;
   logic [4:0]       sel_rs2;
   logic [31:0]      sel_rinst;

   // Hazards look only at the registered scoreboard; a same-cycle writeback does not bypass.
   always_comb begin
      slot_elig = '0;
      for (int k = 0; k < PNUMS; k++) begin
         slot_elig[k] = (POOL_RINST[32*k +: 32] != 32'hFFFF_FFFF)
                     && !((POOL_RS1[5*k +: 5] != 5'd0) && busy_q[POOL_RS1[5*k +: 5]])
                     && !((POOL_RS2[5*k +: 5] != 5'd0) && busy_q[POOL_RS2[5*k +: 5]])
                     && !((POOL_RD[5*k +: 5]  != 5'd0) && busy_q[POOL_RD[5*k +: 5]]);
      end
   end

   // Two passes give the wrapped order ptr..PNUMS-1 then 0..ptr-1.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < PNUMS; k++) begin
         if (!found && (k >= int'(ptr_q)) && slot_elig[k]) begin
            found     = 1'b1;
            grant_idx = PW'(k);
         end
      end
      for (int k = 0; k < PNUMS; k++) begin
         if (!found && (k < int'(ptr_q)) && slot_elig[k]) begin
            found     = 1'b1;
            grant_idx = PW'(k);
         end
      end
   end

   assign grant = RST_N && !FLUSH && (!valid_q || ISSUE_READY) && found;

   always_comb begin
      grant_oh = '0;
      for (int k = 0; k < PNUMS; k++) begin
         grant_oh[k] = grant && (grant_idx == PW'(k));
      end
   end

   assign POOL_ACCEPT = grant_oh;

   always_comb begin
      sel_pc     = '0;
      sel_opcode = '0;
      sel_rd     = '0;
      sel_rs1    = '0;
      sel_rs2    = '0;
      sel_rinst  = '0;
      for (int k = 0; k < PNUMS; k++) begin
         if (grant_oh[k]) begin
            sel_pc     = POOL_PC[32*k +: 32];
            sel_opcode = POOL_OPCODE[17*k +: 17];
            sel_rd     = POOL_RD[5*k +: 5];
            sel_rs1    = POOL_RS1[5*k +: 5];
            sel_rs2    = POOL_RS2[5*k +: 5];
            sel_rinst  = POOL_RINST[32*k +: 32];
         end
      end
   end

   always_comb begin
      valid_d  = valid_q;
      slot_d   = slot_q;
      pc_d     = pc_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rinst_d  = rinst_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      if (FLUSH) begin
         valid_d = 1'b0;
         busy_d  = '0;
         ptr_d   = '0;
      end else begin
         // Clear before set so a same-register set in this cycle leaves the bit at 1.
         if (WB_VALID) busy_d[WB_RD] = 1'b0;
         if (grant) begin
            valid_d  = 1'b1;
            slot_d   = grant_oh;
            pc_d     = sel_pc;
            opcode_d = sel_opcode;
            rd_d     = sel_rd;
            rs1_d    = sel_rs1;
            rs2_d    = sel_rs2;
            rinst_d  = sel_rinst;
            if (sel_rd != 5'd0) busy_d[sel_rd] = 1'b1;
            if (int'(grant_idx) == PNUMS - 1) ptr_d = '0;
            else ptr_d = grant_idx + 1'b1;
         end else if (ISSUE_READY) begin
            valid_d = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q  <= 1'b0;
         slot_q   <= '0;
         pc_q     <= '0;
         opcode_q <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rinst_q  <= 32'h0000_0013;
         busy_q   <= '0;
         ptr_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         slot_q   <= slot_d;
         pc_q     <= pc_d;
         opcode_q <= opcode_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rinst_q  <= rinst_d;
         busy_q   <= busy_d;
         ptr_q    <= ptr_d;
      end
   end

   assign ISSUE_VALID  = valid_q;
   assign ISSUE_SLOT   = slot_q;
   assign ISSUE_PC     = pc_q;
   assign ISSUE_OPCODE = opcode_q;
   assign ISSUE_RD     = rd_q;
   assign ISSUE_RS1    = rs1_q;
   assign ISSUE_RS2    = rs2_q;
   assign ISSUE_RINST  = rinst_q;
   assign BUSY_REGS    = busy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with two pool slots (main core plus one coprocessor).
module tb_issue_scheduler;

   localparam int PNUMS = 2;

   logic                clk;
   logic                rst_n;
   logic                flush;
   logic [32*PNUMS-1:0] pool_pc;
   logic [17*PNUMS-1:0] pool_opcode;
   logic [5*PNUMS-1:0]  pool_rd;
   logic [5*PNUMS-1:0]  pool_rs1;
   logic [5*PNUMS-1:0]  pool_rs2;
   logic [32*PNUMS-1:0] pool_rinst;
   logic [PNUMS-1:0]    pool_accept;
   logic                issue_valid;
   logic                issue_ready;
   logic [PNUMS-1:0]    issue_slot;
   logic [31:0]         issue_pc;
   logic [16:0]         issue_opcode;
   logic [4:0]          issue_rd;
   logic [4:0]          issue_rs1;
   logic [4:0]          issue_rs2;
   logic [31:0]         issue_rinst;
   logic                wb_valid;
   logic [4:0]          wb_rd;
   logic [31:0]         busy_regs;

   int checks = 0;
   int errors = 0;

   issue_scheduler #(.COP_NUMS(1)) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .FLUSH        (flush),
      .POOL_PC      (pool_pc),
      .POOL_OPCODE  (pool_opcode),
      .POOL_RD      (pool_rd),
      .POOL_RS1     (pool_rs1),
      .POOL_RS2     (pool_rs2),
      .POOL_RINST   (pool_rinst),
      .POOL_ACCEPT  (pool_accept),
      .ISSUE_VALID  (issue_valid),
      .ISSUE_READY  (issue_ready),
      .ISSUE_SLOT   (issue_slot),
      .ISSUE_PC     (issue_pc),
      .ISSUE_OPCODE (issue_opcode),
      .ISSUE_RD     (issue_rd),
      .ISSUE_RS1    (issue_rs1),
      .ISSUE_RS2    (issue_rs2),
      .ISSUE_RINST  (issue_rinst),
      .WB_VALID     (wb_valid),
      .WB_RD        (wb_rd),
      .BUSY_REGS    (busy_regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_slot(input int k, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] rinst);
      pool_pc[32*k +: 32]     = pc;
      pool_opcode[17*k +: 17] = 17'h1_0033;
      pool_rd[5*k +: 5]       = rd;
      pool_rs1[5*k +: 5]      = rs1;
      pool_rs2[5*k +: 5]      = rs2;
      pool_rinst[32*k +: 32]  = rinst;
   endtask

   task automatic clear_slot(input int k);
      set_slot(k, 32'h0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
      clear_slot(0); clear_slot(1);
      step; step;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", issue_valid); end
      checks++; if (issue_slot !== 2'b00) begin errors++; $display("FAIL reset_slot: got %b expected 00", issue_slot); end
      checks++; if ({issue_pc, issue_opcode, issue_rd, issue_rs1, issue_rs2} !== 64'h0) begin
         errors++; $display("FAIL reset_fields: got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d expected all 0",
                            issue_pc, issue_opcode, issue_rd, issue_rs1, issue_rs2); end
      checks++; if (issue_rinst !== 32'h0000_0013) begin errors++; $display("FAIL reset_rinst: got %h expected 00000013", issue_rinst); end
      checks++; if (busy_regs !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_regs); end
      rst_n = 1'b1;
      set_slot(0, 32'h40, 5'd2, 5'd0, 5'd0, 32'h11);
      issue_ready = 1'b1;
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL first_accept: got %b expected 01", pool_accept); end
      step;
      checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h40) begin errors++; $display("FAIL first_issue: got valid=%b pc=%h expected 1 00000040", issue_valid, issue_pc); end
      checks++; if (busy_regs !== 32'h4) begin errors++; $display("FAIL first_busy: got %h expected 00000004", busy_regs); end
      // Assert reset mid-cycle while a transfer is pending and a slot is valid.
      clear_slot(0);
      issue_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      set_slot(0, 32'h44, 5'd0, 5'd0, 5'd0, 32'h12);
      #1;
      checks++; if (issue_valid !== 1'b0 || issue_slot !== 2'b00 || issue_pc !== 32'h0) begin
         errors++; $display("FAIL async_reset_out: got valid=%b slot=%b pc=%h expected 0 00 0", issue_valid, issue_slot, issue_pc); end
      checks++; if (issue_rinst !== 32'h0000_0013 || busy_regs !== 32'h0) begin
         errors++; $display("FAIL async_reset_state: got rinst=%h busy=%h expected 00000013 0", issue_rinst, busy_regs); end
      checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL accept_in_reset: got %b expected 00", pool_accept); end
      step;
      clear_slot(0);
      rst_n = 1'b1;
      issue_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         checks++; if (issue_valid !== 1'b0 || pool_accept !== 2'b00) begin
            errors++; $display("FAIL idle_%0d: got valid=%b accept=%b expected 0 00", i, issue_valid, pool_accept); end
      end
   endtask

   task automatic test_round_robin;
      logic [1:0]  exp_slot;
      logic [1:0]  exp_acc;
      logic [31:0] exp_pc;
      set_slot(0, 32'h200, 5'd0, 5'd0, 5'd0, 32'h1000_0001);
      set_slot(1, 32'h300, 5'd0, 5'd0, 5'd0, 32'h2000_0001);
      issue_ready = 1'b1;
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL rr_accept_start: got %b expected 01", pool_accept); end
      for (int i = 0; i < 4; i++) begin
         step;
         exp_slot = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_acc  = (i % 2 == 0) ? 2'b10 : 2'b01;
         exp_pc   = (i % 2 == 0) ? 32'h200 : 32'h300;
         checks++; if (issue_valid !== 1'b1 || issue_slot !== exp_slot || issue_pc !== exp_pc) begin
            errors++; $display("FAIL rr_issue_%0d: got valid=%b slot=%b pc=%h expected 1 %b %h",
                               i, issue_valid, issue_slot, issue_pc, exp_slot, exp_pc); end
         checks++; if (pool_accept !== exp_acc) begin errors++; $display("FAIL rr_accept_%0d: got %b expected %b", i, pool_accept, exp_acc); end
      end
      clear_slot(0); clear_slot(1);
      step;
      checks++; if (issue_valid !== 1'b0 || issue_pc !== 32'h300) begin
         errors++; $display("FAIL rr_drain: got valid=%b pc=%h expected 0 00000300", issue_valid, issue_pc); end
   endtask

   task automatic test_raw;
      set_slot(0, 32'h400, 5'd5, 5'd0, 5'd0, 32'h500);
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL raw_accept_producer: got %b expected 01", pool_accept); end
      step;
      checks++; if (issue_rd !== 5'd5 || busy_regs !== 32'h20) begin errors++; $display("FAIL raw_producer: got rd=%0d busy=%h expected 5 00000020", issue_rd, busy_regs); end
      set_slot(0, 32'h404, 5'd6, 5'd5, 5'd0, 32'h504);
      #1;
      checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL raw_blocked: got %b expected 00", pool_accept); end
      step;
      checks++; if (issue_valid !== 1'b0 || busy_regs[5] !== 1'b1) begin
         errors++; $display("FAIL raw_wait: got valid=%b busy5=%b expected 0 1", issue_valid, busy_regs[5]); end
      wb_valid = 1'b1; wb_rd = 5'd5;
      #1;
      checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL raw_no_bypass: got %b expected 00", pool_accept); end
      step;
      wb_valid = 1'b0;
      #1;
      checks++; if (pool_accept !== 2'b01 || busy_regs !== 32'h0) begin
         errors++; $display("FAIL raw_release: got accept=%b busy=%h expected 01 0", pool_accept, busy_regs); end
      step;
      checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h404 || busy_regs !== 32'h40) begin
         errors++; $display("FAIL raw_consumer: got valid=%b pc=%h busy=%h expected 1 00000404 00000040", issue_valid, issue_pc, busy_regs); end
      clear_slot(0);
      wb_valid = 1'b1; wb_rd = 5'd6;
      step;
      wb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0 || busy_regs !== 32'h0) begin
         errors++; $display("FAIL raw_cleanup: got valid=%b busy=%h expected 0 0", issue_valid, busy_regs); end
   endtask

   task automatic test_backpressure;
      set_slot(0, 32'h100, 5'd0, 5'd0, 5'd0, 32'h600);
      issue_ready = 1'b0;
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL bp_accept_first: got %b expected 01", pool_accept); end
      step;
      clear_slot(0);
      set_slot(1, 32'h180, 5'd0, 5'd0, 5'd0, 32'h601);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL bp_accept_%0d: got %b expected 00", i, pool_accept); end
         step;
         checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h100 || issue_slot !== 2'b01 || issue_rinst !== 32'h600) begin
            errors++; $display("FAIL bp_hold_%0d: got valid=%b pc=%h slot=%b rinst=%h expected 1 00000100 01 00000600",
                               i, issue_valid, issue_pc, issue_slot, issue_rinst); end
      end
      issue_ready = 1'b1;
      #1;
      checks++; if (pool_accept !== 2'b10) begin errors++; $display("FAIL bp_release_accept: got %b expected 10", pool_accept); end
      step;
      checks++; if (issue_valid !== 1'b1 || issue_pc !== 32'h180 || issue_slot !== 2'b10) begin
         errors++; $display("FAIL bp_next: got valid=%b pc=%h slot=%b expected 1 00000180 10", issue_valid, issue_pc, issue_slot); end
      clear_slot(1);
      step;
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", issue_valid); end
   endtask

   task automatic test_collision;
      set_slot(0, 32'h700, 5'd7, 5'd0, 5'd0, 32'h700);
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL col_accept_first: got %b expected 01", pool_accept); end
      step;
      checks++; if (busy_regs !== 32'h80) begin errors++; $display("FAIL col_busy_set: got %h expected 00000080", busy_regs); end
      clear_slot(0);
      set_slot(1, 32'h710, 5'd7, 5'd0, 5'd0, 32'h710);
      wb_valid = 1'b1; wb_rd = 5'd7;
      #1;
      checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL col_waw_blocked: got %b expected 00", pool_accept); end
      step;
      checks++; if (busy_regs !== 32'h0 || issue_valid !== 1'b0) begin
         errors++; $display("FAIL col_wb_clear: got busy=%h valid=%b expected 0 0", busy_regs, issue_valid); end
      #1;
      checks++; if (pool_accept !== 2'b10) begin errors++; $display("FAIL col_accept_second: got %b expected 10", pool_accept); end
      step;
      checks++; if (busy_regs !== 32'h80 || issue_pc !== 32'h710) begin
         errors++; $display("FAIL col_set_wins: got busy=%h pc=%h expected 00000080 00000710", busy_regs, issue_pc); end
      clear_slot(1);
      step;
      wb_valid = 1'b0;
      checks++; if (busy_regs !== 32'h0 || issue_valid !== 1'b0) begin
         errors++; $display("FAIL col_cleanup: got busy=%h valid=%b expected 0 0", busy_regs, issue_valid); end
   endtask

   task automatic test_flush;
      clear_slot(0);
      set_slot(1, 32'h900, 5'd9, 5'd0, 5'd0, 32'h900);
      #1;
      checks++; if (pool_accept !== 2'b10) begin errors++; $display("FAIL fl_accept_9: got %b expected 10", pool_accept); end
      step;
      clear_slot(1);
      set_slot(0, 32'h800, 5'd3, 5'd0, 5'd0, 32'h800);
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL fl_accept_3: got %b expected 01", pool_accept); end
      step;
      checks++; if (busy_regs !== 32'h208 || issue_valid !== 1'b1) begin
         errors++; $display("FAIL fl_setup: got busy=%h valid=%b expected 00000208 1", busy_regs, issue_valid); end
      set_slot(0, 32'hA00, 5'd0, 5'd0, 5'd0, 32'hA00);
      set_slot(1, 32'hB00, 5'd0, 5'd0, 5'd0, 32'hB00);
      flush = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd3;
      #1;
      checks++; if (pool_accept !== 2'b00) begin errors++; $display("FAIL fl_accept_blocked: got %b expected 00", pool_accept); end
      step;
      flush = 1'b0;
      wb_valid = 1'b0;
      checks++; if (issue_valid !== 1'b0 || busy_regs !== 32'h0) begin
         errors++; $display("FAIL fl_cleared: got valid=%b busy=%h expected 0 0", issue_valid, busy_regs); end
      #1;
      checks++; if (pool_accept !== 2'b01) begin errors++; $display("FAIL fl_ptr_restart: got %b expected 01", pool_accept); end
      step;
      checks++; if (issue_slot !== 2'b01 || issue_pc !== 32'hA00) begin
         errors++; $display("FAIL fl_next_issue: got slot=%b pc=%h expected 01 00000a00", issue_slot, issue_pc); end
      clear_slot(0); clear_slot(1);
      step;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_raw;
      test_backpressure;
      test_collision;
      test_flush;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue scheduler between the instruction pool and the execute stage. Each cycle it scans the `PNUMS` pool slots: slot 0 is the main core and slots 1..`COP_NUMS` are the coprocessors. It picks one valid, hazard-free slot in round-robin order, acknowledges it to the pool, and holds the chosen instruction in a registered valid/ready output stage. A 32-entry register scoreboard tracks in-flight destinations for RAW and WAW checks and is released by writeback.

## Interface
- `COP_NUMS`, default 32'd1: number of coprocessor slots.
- `PNUMS`, default `COP_NUMS+1`: total pool slots.
- `CLK` in, 1: clock, rising edge.
- `RST_N` in, 1: asynchronous, active-low reset.
- `FLUSH` in, 1: synchronous pipeline flush.
- `POOL_PC` in, 32*PNUMS: slot k occupies bits [32k+31:32k]. The same packing applies to all `POOL_*` buses.
- `POOL_OPCODE` in, 17*PNUMS: per-slot opcode.
- `POOL_RD`, `POOL_RS1`, `POOL_RS2` in, 5*PNUMS each: per-slot register indices.
- `POOL_RINST` in, 32*PNUMS: per-slot raw instruction. The value 32'hFFFF_FFFF marks an empty slot.
- `POOL_ACCEPT` out, PNUMS: one-hot, combinational; slot consumed this cycle.
- `ISSUE_VALID` out, 1: output stage holds an instruction.
- `ISSUE_READY` in, 1: execute stage takes the instruction this cycle.
- `ISSUE_SLOT` out, PNUMS: one-hot source slot of the held instruction.
- `ISSUE_PC` out, 32; `ISSUE_OPCODE` out, 17; `ISSUE_RD`, `ISSUE_RS1`, `ISSUE_RS2` out, 5 each; `ISSUE_RINST` out, 32: the held instruction fields.
- `WB_VALID` in, 1: a writeback completes this cycle.
- `WB_RD` in, 5: destination register of that writeback.
- `BUSY_REGS` out, 32: scoreboard, for debug/visibility.

## Operation
- **Slot valid:** `POOL_RINST[k] != 32'hFFFF_FFFF`.
- **Slot hazard:**
  - (RS1≠0 and busy[RS1]), or
  - (RS2≠0 and busy[RS2]), or
  - (RD≠0 and busy[RD]).
  - busy is the registered scoreboard; there is no bypass from same-cycle `WB_VALID`.
- **Eligible:** valid and no hazard.
- **Can grant:** `!FLUSH && (!ISSUE_VALID || ISSUE_READY)`.
- **Round-robin:** pointer `ptr` (width clog2(PNUMS), minimum 1).
  - Search order is ptr, ptr+1, …, PNUMS-1, 0, …, ptr-1.
  - The first eligible slot k is granted.
  - After a grant, ptr = (k+1) mod PNUMS. With no grant, ptr is unchanged.
- **On grant:**
  - `POOL_ACCEPT[k]`=1 in the same cycle.
  - The output stage loads slot k fields and `ISSUE_SLOT`=1<<k, and `ISSUE_VALID`=1 at the next edge.
  - busy[RD] is set if RD≠0.
- **Output stage:**
  - Consumed (`ISSUE_READY`=1) with no new grant: `ISSUE_VALID`→0 and fields hold their old values.
  - Not consumed: all outputs hold stable.
- **Scoreboard update per edge:**
  - The `WB_VALID` clear of `WB_RD` is applied first, then the grant set.
  - If both target the same register in one cycle, the set wins and the bit stays 1.
  - busy[0] is always 0. `WB_VALID` with `WB_RD`=0 has no effect.
  - A writeback to a non-busy register is ignored.
- **FLUSH:**
  - Synchronous; highest priority after reset.
  - `POOL_ACCEPT`=0 in that cycle.
  - At the edge: `ISSUE_VALID`→0, `BUSY_REGS`→0, ptr→0.
  - A same-cycle `WB_VALID` is discarded.
- **Reset (`RST_N`=0, asynchronous):** `ISSUE_VALID`=0, `ISSUE_SLOT`=0, `ISSUE_PC`=0, `ISSUE_OPCODE`=0, `ISSUE_RD`/`ISSUE_RS1`/`ISSUE_RS2`=0, `ISSUE_RINST`=32'h0000_0013, `BUSY_REGS`=0, ptr=0.
  - `POOL_ACCEPT` is 0 while in reset.
  - Reset asserted mid-transfer drops the held instruction without completing the handshake.
- **Arithmetic:** pointer wrap is mod PNUMS and must work for non-power-of-two PNUMS. When PNUMS=1, ptr stays 0.

## Timing
- **Grant latency:** slot eligible in cycle n → `POOL_ACCEPT` in cycle n → `ISSUE_VALID` from cycle n+1.
- **Throughput:** one issue per cycle when `ISSUE_READY` is held at 1 and eligible slots exist.
- **Backpressure:** `ISSUE_VALID`=1 with `ISSUE_READY`=0 → no grant and `POOL_ACCEPT`=0. The pool sees no accept and must hold its contents.
- **RAW release:** `WB_VALID`/`WB_RD`=x in cycle n → busy[x]=0 after the edge → a dependent grant occurs in cycle n+1 at the earliest.
- **Back-to-back dependency:** an instruction whose source is the RD of the instruction granted in cycle n is never granted before the corresponding writeback.
- **Combinational path:** `POOL_ACCEPT` depends combinationally on `POOL_*`, `ISSUE_READY`, `FLUSH` and registered state only.

## Test plan
- **Reset and idle:** `RST_N` low mid-cycle → all outputs at reset values immediately. Release with all slots 32'hFFFF_FFFF → `ISSUE_VALID` stays 0 and `POOL_ACCEPT`=0.
- **Round-robin (PNUMS=2):** both slots valid with no hazards, `ISSUE_READY`=1 → `ISSUE_SLOT` sequence 01, 10, 01, 10, one issue per cycle.
- **RAW hazard:**
  - Issue slot 0 with RD=5.
  - Next instruction has RS1=5 → not granted; `BUSY_REGS`[5]=1.
  - Assert `WB_VALID`, `WB_RD`=5 in cycle n → grant in cycle n+1.
- **Backpressure:** `ISSUE_READY`=0 for 3 cycles with `ISSUE_PC`=0x100 held → outputs stable and `POOL_ACCEPT`=0. `ISSUE_READY`=1 → the next grant appears in the same cycle.
- **Set/clear collision:**
  - busy[7]=1.
  - In one cycle, `WB_RD`=7 and a grant of an instruction with RD=7.
  - Expected: `BUSY_REGS`[7]=1 afterward.
- **Flush:**
  - Busy={3,9}, `ISSUE_VALID`=1, ptr=1.
  - `FLUSH` for one cycle → `POOL_ACCEPT`=0, then `ISSUE_VALID`=0 and `BUSY_REGS`=0.
  - The next grant starts its search at slot 0.
